i2c_dyn_ctrl_v2: RTL and testbench

Second-generation I2C dynamic-mode controller. It watches the TX FIFO command stream: bit DW = start, bit DW+1 = stop, bits DW-1:0 = address or data. It drives MSMS, RSTA and TXAK control strobes into the control-register block. A start+read address word is followed by a length word; the block tracks the received byte count, NACKs the final byte, and issues a deferred stop when the read completes.

---
 rtl/i2c_dyn_ctrl_v2.sv | 190 +++++++++++++++++++
 tb/tb_i2c_dyn_ctrl_v2.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_dyn_ctrl_v2.sv
// i2c_dyn_ctrl_v2 -- dynamic-mode I2C master controller (second generation).
//
// Watches the TX FIFO command stream and drives MSMS/RSTA/TXAK control-register
// strobes. A TX FIFO word is {stop, start, byte[DW-1:0]}. A start word with
// bit0=1 (read address) is followed by a length word. The block then counts
// received bytes, NACKs the final byte and issues the stop that was carried
// on the length word once the read completes.
//
// Handshake: a TX word is consumed on a cycle where tx_fifo_rd=1. A received
// byte is signalled by a single-cycle rx_fifo_wr=1. Both are sampled on the
// rising clock edge and have no back-pressure.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   cr_en              core enable; low acts like reset and gates all outputs
//   cr_msms            current MSMS bit (1 = this master owns the bus)
//   tx_fifo_empty      TX FIFO empty
//   tx_fifo_dout       TX FIFO head word {stop, start, data}
//   tx_fifo_rd         TX FIFO pop
//   rx_fifo_wr         received byte written to the RX FIFO
//   cr_msms_set        start on an idle bus (combinational)
//   cr_rsta_set        repeated start on an owned bus (combinational)
//   cr_msms_clr        stop: write stop (combinational) or read stop (pulse)
//   cr_txak_set        pulse: NACK the next byte
//   cr_txak_clr        pulse: ACK the following bytes
//   rd_active          state is RD_LEN or RD
//   rcnt               bytes remaining in the current read
//   rd_done            pulse: last read byte received
//   err_seq            pulse: protocol-sequence error
//   err_ovr            pulse: RX write with no read pending
module i2c_dyn_ctrl_v2 #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cr_en,
    input  logic          cr_msms,
    input  logic          tx_fifo_empty,
    input  logic [DW+1:0] tx_fifo_dout,
    input  logic          tx_fifo_rd,
    input  logic          rx_fifo_wr,
    output logic          cr_msms_set,
    output logic          cr_rsta_set,
    output logic          cr_msms_clr,
    output logic          cr_txak_set,
    output logic          cr_txak_clr,
    output logic          rd_active,
    output logic [CW-1:0] rcnt,
    output logic          rd_done,
    output logic          err_seq,
    output logic          err_ovr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WR     = 2'd1;
    localparam logic [1:0] ST_RD_LEN = 2'd2;
    localparam logic [1:0] ST_RD     = 2'd3;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_TWO = CW'(2);

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] rcnt_q, rcnt_nxt;
    logic          stop_pend, stop_pend_nxt;

    // Registered single-cycle pulses.
    logic msms_clr_q, msms_clr_nxt;
    logic txak_set_q, txak_set_nxt;
    logic txak_clr_q, txak_clr_nxt;
    logic rd_done_q, rd_done_nxt;
    logic err_seq_q, err_seq_nxt;
    logic err_ovr_q, err_ovr_nxt;

    logic          head_start, head_stop;
    logic [CW-1:0] head_len;
    logic          strobe_ok;
    logic          wr_stop;

    assign head_start = tx_fifo_dout[DW];
    assign head_stop  = tx_fifo_dout[DW+1];

    // Length word is the data field zero-extended to the counter width.
    always_comb begin
        head_len = '0;
        head_len[DW-1:0] = tx_fifo_dout[DW-1:0];
    end

    // Strobes are level outputs: held for as long as the qualifying word sits
    // at the FIFO head, so the control-register block sees them until the pop.
    assign strobe_ok = cr_en && !tx_fifo_empty && (state == ST_IDLE || state == ST_WR);
    assign wr_stop   = strobe_ok && head_stop && !head_start;

    assign cr_msms_set = strobe_ok && head_start && !cr_msms;
    assign cr_rsta_set = strobe_ok && head_start && cr_msms;
    assign cr_msms_clr = wr_stop || (cr_en && msms_clr_q);
    assign cr_txak_set = cr_en && txak_set_q;
    assign cr_txak_clr = cr_en && txak_clr_q;
    assign rd_done     = cr_en && rd_done_q;
    assign err_seq     = cr_en && err_seq_q;
    assign err_ovr     = cr_en && err_ovr_q;
    assign rd_active   = cr_en && (state == ST_RD_LEN || state == ST_RD);
    assign rcnt        = cr_en ? rcnt_q : '0;

    always_comb begin
        state_nxt     = state;
        rcnt_nxt      = rcnt_q;
        stop_pend_nxt = stop_pend;
        msms_clr_nxt  = 1'b0;
        txak_set_nxt  = 1'b0;
        txak_clr_nxt  = 1'b0;
        rd_done_nxt   = 1'b0;
        err_seq_nxt   = 1'b0;
        err_ovr_nxt   = 1'b0;

        case (state)
            ST_IDLE, ST_WR: begin
                if (tx_fifo_rd) begin
                    if (head_start) begin
                        state_nxt = tx_fifo_dout[0] ? ST_RD_LEN : ST_WR;
                    end else if (state == ST_WR) begin
                        if (head_stop) state_nxt = ST_IDLE;
                    end else begin
                        err_seq_nxt = 1'b1;
                    end
                end
            end
            ST_RD_LEN: begin
                if (tx_fifo_rd) begin
                    rcnt_nxt      = head_len;
                    stop_pend_nxt = head_stop;
                    if (head_len == '0) begin
                        // Zero-length read is illegal; still honour its stop.
                        err_seq_nxt  = 1'b1;
                        msms_clr_nxt = head_stop;
                        state_nxt    = ST_IDLE;
                    end else begin
                        txak_set_nxt = (head_len == CNT_ONE);
                        txak_clr_nxt = (head_len != CNT_ONE);
                        state_nxt    = ST_RD;
                    end
                end
            end
            default: begin // ST_RD
                if (tx_fifo_rd) err_seq_nxt = 1'b1;
                if (rx_fifo_wr) begin
                    if (rcnt_q != '0) rcnt_nxt = rcnt_q - CNT_ONE;
                    // Set TXAK one byte ahead so the last byte gets NACKed.
                    if (rcnt_q == CNT_TWO) txak_set_nxt = 1'b1;
                    if (rcnt_q == CNT_ONE) begin
                        rd_done_nxt = 1'b1;
                        if (stop_pend) begin
                            msms_clr_nxt = 1'b1;
                            state_nxt    = ST_IDLE;
                        end else begin
                            state_nxt = ST_WR;
                        end
                    end
                end
            end
        endcase

        if (rx_fifo_wr && state != ST_RD) err_ovr_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn || !cr_en) begin
            state      <= ST_IDLE;
            rcnt_q     <= '0;
            stop_pend  <= 1'b0;
            msms_clr_q <= 1'b0;
            txak_set_q <= 1'b0;
            txak_clr_q <= 1'b0;
            rd_done_q  <= 1'b0;
            err_seq_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
        end else begin
            state      <= state_nxt;
            rcnt_q     <= rcnt_nxt;
            stop_pend  <= stop_pend_nxt;
            msms_clr_q <= msms_clr_nxt;
            txak_set_q <= txak_set_nxt;
            txak_clr_q <= txak_clr_nxt;
            rd_done_q  <= rd_done_nxt;
            err_seq_q  <= err_seq_nxt;
            err_ovr_q  <= err_ovr_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_dyn_ctrl_v2.sv
// Self-checking bench for i2c_dyn_ctrl_v2: directed command sequences followed
// by randomized traffic, every output compared each cycle against a
// transaction-level reference model of the controller.
module tb_i2c_dyn_ctrl_v2;

    localparam int DW = 8;
    localparam int CW = 8;

    // Reference model phases (bench-local naming).
    localparam int PH_IDLE = 0;
    localparam int PH_WRITE = 1;
    localparam int PH_WANT_LEN = 2;
    localparam int PH_READING = 3;

    logic          clk = 1'b0;
    logic          rstn, cr_en, cr_msms, tx_fifo_empty, tx_fifo_rd, rx_fifo_wr;
    logic [DW+1:0] tx_fifo_dout;
    logic          cr_msms_set, cr_rsta_set, cr_msms_clr, cr_txak_set, cr_txak_clr;
    logic          rd_active, rd_done, err_seq, err_ovr;
    logic [CW-1:0] rcnt;

    int errors = 0;
    int checks = 0;

    // Model state: transfer phase, bytes still owed, whether a stop follows
    // the read, and the pulses promised for the current cycle.
    int phase = PH_IDLE;
    int bytes_left = 0;
    bit stop_after = 1'b0;
    bit p_clr, p_tks, p_tkc, p_done, p_seq, p_ovr;

    i2c_dyn_ctrl_v2 #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rstn(rstn), .cr_en(cr_en), .cr_msms(cr_msms),
        .tx_fifo_empty(tx_fifo_empty), .tx_fifo_dout(tx_fifo_dout),
        .tx_fifo_rd(tx_fifo_rd), .rx_fifo_wr(rx_fifo_wr),
        .cr_msms_set(cr_msms_set), .cr_rsta_set(cr_rsta_set),
        .cr_msms_clr(cr_msms_clr), .cr_txak_set(cr_txak_set),
        .cr_txak_clr(cr_txak_clr), .rd_active(rd_active), .rcnt(rcnt),
        .rd_done(rd_done), .err_seq(err_seq), .err_ovr(err_ovr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic clear_pulses();
        p_clr = 0; p_tks = 0; p_tkc = 0; p_done = 0; p_seq = 0; p_ovr = 0;
    endtask

    // Expected outputs for the current cycle from the model and live inputs.
    task automatic check_outputs();
        bit at_head, is_start, is_stop;
        at_head  = cr_en && !tx_fifo_empty && (phase == PH_IDLE || phase == PH_WRITE);
        is_start = tx_fifo_dout[DW];
        is_stop  = tx_fifo_dout[DW+1];
        check("msms_set", 32'(cr_msms_set), 32'(at_head && is_start && !cr_msms));
        check("rsta_set", 32'(cr_rsta_set), 32'(at_head && is_start && cr_msms));
        check("msms_clr", 32'(cr_msms_clr), 32'((at_head && is_stop && !is_start) || (cr_en && p_clr)));
        check("txak_set", 32'(cr_txak_set), 32'(cr_en && p_tks));
        check("txak_clr", 32'(cr_txak_clr), 32'(cr_en && p_tkc));
        check("rd_done",  32'(rd_done),     32'(cr_en && p_done));
        check("err_seq",  32'(err_seq),     32'(cr_en && p_seq));
        check("err_ovr",  32'(err_ovr),     32'(cr_en && p_ovr));
        check("rd_active", 32'(rd_active),  32'(cr_en && (phase == PH_WANT_LEN || phase == PH_READING)));
        check("rcnt",     32'(rcnt),        cr_en ? 32'(bytes_left) : 32'd0);
    endtask

    // Advance the model by one clock edge using the inputs that were applied.
    task automatic model_edge();
        bit pop, got, is_start, is_stop;
        int len;
        pop      = tx_fifo_rd;
        got      = rx_fifo_wr;
        is_start = tx_fifo_dout[DW];
        is_stop  = tx_fifo_dout[DW+1];
        len      = int'(tx_fifo_dout[DW-1:0]);
        clear_pulses();
        if (!rstn || !cr_en) begin
            phase = PH_IDLE;
            bytes_left = 0;
            stop_after = 0;
            return;
        end
        if (got && phase != PH_READING) p_ovr = 1;
        if (phase == PH_READING) begin
            if (pop) p_seq = 1;
            if (got && bytes_left > 0) begin
                bytes_left = bytes_left - 1;
                if (bytes_left == 1) p_tks = 1;        // next byte is the last one
                if (bytes_left == 0) begin
                    p_done = 1;
                    p_clr  = stop_after;
                    phase  = stop_after ? PH_IDLE : PH_WRITE;
                end
            end
        end else if (phase == PH_WANT_LEN) begin
            if (pop) begin
                bytes_left = len;
                stop_after = is_stop;
                if (len == 0) begin
                    p_seq = 1;
                    p_clr = is_stop;
                    phase = PH_IDLE;
                end else begin
                    if (len == 1) p_tks = 1; else p_tkc = 1;
                    phase = PH_READING;
                end
            end
        end else if (pop) begin
            if (is_start) phase = tx_fifo_dout[0] ? PH_WANT_LEN : PH_WRITE;
            else if (phase == PH_WRITE) begin
                if (is_stop) phase = PH_IDLE;
            end else p_seq = 1;
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input bit en, input bit rst_n, input bit empty, input logic [DW+1:0] word,
                       input bit pop, input bit wr, input bit msms);
        cr_en = en;
        rstn = rst_n;
        tx_fifo_empty = empty;
        tx_fifo_dout = word;
        tx_fifo_rd = pop && !empty;
        rx_fifo_wr = wr;
        cr_msms = msms;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_cycles(input int n, input bit msms);
        for (int i = 0; i < n; i++) cyc(1, 1, 1, '0, 0, 0, msms);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_pulses();
        cr_en = 0; rstn = 0; tx_fifo_empty = 1; tx_fifo_dout = '0;
        tx_fifo_rd = 0; rx_fifo_wr = 0; cr_msms = 0;
        @(posedge clk);
        #1;
        cyc(1, 0, 1, '0, 0, 0, 0);
        cyc(1, 0, 1, '0, 0, 0, 0);
        idle_cycles(1, 0);

        // Write transfer with stop.
        cyc(1, 1, 0, 10'h1A4, 0, 0, 0);
        cyc(1, 1, 0, 10'h1A4, 1, 0, 0);
        cyc(1, 1, 0, 10'h055, 1, 0, 1);
        cyc(1, 1, 0, 10'h266, 0, 0, 1);
        cyc(1, 1, 0, 10'h266, 1, 0, 1);
        idle_cycles(2, 0);

        // Read of 3 bytes with stop.
        cyc(1, 1, 0, 10'h1A5, 1, 0, 0);
        cyc(1, 1, 0, 10'h203, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            idle_cycles(1, 1);
            cyc(1, 1, 1, '0, 0, 1, 1);
        end
        idle_cycles(2, 0);

        // Read of 1 byte without stop, then repeated start.
        cyc(1, 1, 0, 10'h1A5, 1, 0, 0);
        cyc(1, 1, 0, 10'h001, 1, 0, 1);
        idle_cycles(1, 1);
        cyc(1, 1, 1, '0, 0, 1, 1);
        idle_cycles(1, 1);
        cyc(1, 1, 0, 10'h1A4, 0, 0, 1);
        cyc(1, 1, 0, 10'h1A4, 1, 0, 1);
        cyc(1, 1, 0, 10'h266, 1, 0, 1);
        idle_cycles(1, 0);

        // Zero-length read with stop.
        cyc(1, 1, 0, 10'h1A5, 1, 0, 0);
        cyc(1, 1, 0, 10'h200, 1, 0, 1);
        idle_cycles(2, 0);

        // Sequence errors.
        cyc(1, 1, 1, '0, 0, 1, 0);
        cyc(1, 1, 0, 10'h012, 1, 0, 0);
        idle_cycles(2, 0);

        // Abort mid-read via cr_en, then via reset.
        for (int k = 0; k < 2; k++) begin
            cyc(1, 1, 0, 10'h1A5, 1, 0, 0);
            cyc(1, 1, 0, 10'h205, 1, 0, 1);
            idle_cycles(1, 1);
            cyc(k == 0 ? 1'b0 : 1'b1, k == 0 ? 1'b1 : 1'b0, 1, '0, 0, 0, 1);
            idle_cycles(2, 0);
        end

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            bit en, rst_n, empty, st, sp, pop, wr, msms;
            logic [DW-1:0] data;
            en    = ($urandom_range(0, 99) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            empty = ($urandom_range(0, 3) == 0);
            st    = ($urandom_range(0, 2) == 0);
            sp    = ($urandom_range(0, 3) == 0);
            if (phase == PH_WANT_LEN && $urandom_range(0, 3) != 0)
                data = DW'($urandom_range(0, 4));
            else
                data = DW'($urandom_range(0, 255));
            pop  = ($urandom_range(0, 1) == 1);
            wr   = (phase == PH_READING) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            msms = ($urandom_range(0, 1) == 1);
            cyc(en, rst_n, empty, {sp, st, data}, pop, wr, msms);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
